// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared frame geometry and FSM states for tdm_demux8 (TDM_DEMUX_PARITY_EN adds a parity slot)
package tdm_pkg;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int TDM_SLOTS = 9;
`else
  localparam int TDM_SLOTS = 8;
`endif

  localparam int SLOT_W = $clog2(TDM_SLOTS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(TDM_SLOTS - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - slot index counter with clear, load-to-1 and wrap at the last slot
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slot <= '0;
    end else if (load) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - 8-channel TDM receive demultiplexer with frame lock; TDM_DEMUX_PARITY_EN adds even parity slot
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int LOCK_CNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       din,
  input  logic       fsync,
  output logic [7:0] d,
  output logic       dvalid,
  output logic       locked,
`ifdef TDM_DEMUX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       sync_err
);

  state_t            state, state_n;
  logic [3:0]        good_cnt, good_n;
  logic [7:0]        acc, acc_n;
  logic [7:0]        d_n;
  logic              dvalid_n, serr_n;
  logic              slot_clr, slot_load, slot_inc;
  logic [SLOT_W-1:0] slot;
`ifdef TDM_DEMUX_PARITY_EN
  logic              perr_n;
`endif

  tdm_slot_ctr u_slot_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (slot_clr),
    .load (slot_load),
    .inc  (slot_inc),
    .slot (slot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      good_cnt <= '0;
      acc      <= '0;
      d        <= '0;
      dvalid   <= 1'b0;
      sync_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      good_cnt <= good_n;
      acc      <= acc_n;
      d        <= d_n;
      dvalid   <= dvalid_n;
      sync_err <= serr_n;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    good_n    = good_cnt;
    acc_n     = acc;
    d_n       = d;
    dvalid_n  = 1'b0;
    serr_n    = 1'b0;
    slot_clr  = 1'b0;
    slot_load = 1'b0;
    slot_inc  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    perr_n    = 1'b0;
`endif
    if (ce) begin
      if (state == HUNT) begin
        if (fsync) begin
          acc_n[0]  = din;
          slot_load = 1'b1;
          good_n    = 4'd1;
          state_n   = (LOCK_CNT == 1) ? LOCKED : ACQ;
        end
      end else if (slot == '0 && !fsync) begin
        serr_n   = 1'b1;
        slot_clr = 1'b1;
        good_n   = '0;
        state_n  = HUNT;
      end else if (slot != '0 && fsync) begin
        // Early marker: restart the frame here rather than dropping to HUNT.
        serr_n    = 1'b1;
        acc_n[0]  = din;
        slot_load = 1'b1;
        good_n    = 4'd1;
        state_n   = ACQ;
      end else begin
        slot_inc = 1'b1;
        if (slot == '0 && state == ACQ) begin
          if (good_cnt >= 4'(LOCK_CNT - 1)) begin
            state_n = LOCKED;
          end else begin
            good_n = good_cnt + 4'd1;
          end
        end
        if (int'(slot) < 8) begin
          acc_n[slot[2:0]] = din;
        end
        if (slot == LAST_SLOT) begin
          dvalid_n = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
          d_n    = acc;
          perr_n = ^{acc, din};
`else
          d_n    = {din, acc[6:0]};
`endif
        end
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - randomized self-checking bench for tdm_demux8 against a frame-level reference model
module tb_tdm_demux8;

  localparam int LOCK = 2;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int NS = 9;
`else
  localparam int NS = 8;
`endif
  localparam int M_HUNT = 0, M_ACQ = 1, M_LOCKED = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, ce = 1'b0, din = 1'b0, fsync = 1'b0;
  logic [7:0] d;
  logic       dvalid, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad   = 0;

  int         m_mode = M_HUNT;
  int         m_good = 0;
  bit         fq[$];
  logic [7:0] e_d = 8'h00;
  logic       e_dv = 1'b0, e_se = 1'b0, e_pe = 1'b0, e_lk = 1'b0;

  tdm_demux8 #(.LOCK_CNT(LOCK)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .din        (din),
    .fsync      (fsync),
    .d          (d),
    .dvalid     (dvalid),
    .locked     (locked),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err (parity_err),
`endif
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: the received frame is a queue of bits since the accepted marker.
  task automatic model(input logic c, input logic di, input logic fs, input logic r);
    int ones;
    e_dv = 1'b0;
    e_se = 1'b0;
    e_pe = 1'b0;
    if (r) begin
      m_mode = M_HUNT;
      m_good = 0;
      fq.delete();
      e_d = 8'h00;
    end else if (c) begin
      if (m_mode == M_HUNT) begin
        if (fs) begin
          fq = {di};
          m_good = 1;
          m_mode = (LOCK == 1) ? M_LOCKED : M_ACQ;
        end
      end else if (fq.size() == 0 && !fs) begin
        e_se = 1'b1;
        m_mode = M_HUNT;
      end else if (fq.size() != 0 && fs) begin
        e_se = 1'b1;
        fq = {di};
        m_good = 1;
        m_mode = M_ACQ;
      end else begin
        if (fq.size() == 0 && m_mode == M_ACQ) begin
          m_good++;
          if (m_good >= LOCK) m_mode = M_LOCKED;
        end
        fq.push_back(di);
        if (fq.size() == NS) begin
          e_dv = 1'b1;
          ones = 0;
          for (int k = 0; k < NS; k++) begin
            if (k < 8) e_d[k] = fq[k];
            ones += int'(fq[k]);
          end
          e_pe = (ones % 2) != 0;
          fq.delete();
        end
      end
    end
    e_lk = (m_mode == M_LOCKED);
  endtask

  task automatic cycle(input logic c, input logic di, input logic fs, input logic r);
    @(negedge clk);
    ce = c;
    din = di;
    fsync = fs;
    rst = r;
    model(c, di, fs, r);
    @(posedge clk);
    #1;
    check("d", d, e_d);
    check("dvalid", {7'b0, dvalid}, {7'b0, e_dv});
    check("locked", {7'b0, locked}, {7'b0, e_lk});
    check("sync_err", {7'b0, sync_err}, {7'b0, e_se});
`ifdef TDM_DEMUX_PARITY_EN
    check("parity_err", {7'b0, parity_err}, {7'b0, e_pe});
`endif
  endtask

  // Sends the first nslots slots of a frame, with gap idle (ce=0) cycles of junk before each slot.
  task automatic send_frame(input logic [7:0] data, input int gap, input int nslots,
                            input bit fs0, input bit pflip);
    logic b;
    for (int s = 0; s < nslots; s++) begin
      repeat (gap) cycle(1'b0, 1'($urandom), 1'($urandom), 1'b0);
      b = (s < 8) ? data[s] : ((^data) ^ pflip);
      cycle(1'b1, b, (s == 0) ? fs0 : 1'b0, 1'b0);
    end
  endtask

  initial begin
    int r;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    send_frame(8'hA5, 0, NS, 1'b1, 1'b0);
    send_frame(8'h3C, 0, NS, 1'b1, 1'b0);
    send_frame(8'hFF, 0, NS, 1'b1, 1'b0);
    send_frame(8'h81, 2, NS, 1'b1, 1'b0);

    send_frame(8'h5A, 0, 3, 1'b1, 1'b0);
    send_frame(8'hC3, 0, NS, 1'b1, 1'b0);
    send_frame(8'h96, 0, NS, 1'b1, 1'b0);
    send_frame(8'h11, 0, NS, 1'b0, 1'b0);
    send_frame(8'h22, 0, NS, 1'b1, 1'b0);
    send_frame(8'h44, 0, NS, 1'b1, 1'b0);

    send_frame(8'hE7, 0, 5, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'hE7, 0, NS - 5, 1'b0, 1'b0);
    send_frame(8'h07, 1, NS, 1'b1, 1'b1);
    send_frame(8'h07, 0, NS, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 19));
      case (r)
        0: send_frame(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, NS - 1)), 1'b1, 1'b0);
        1: send_frame(8'($urandom), 0, NS, 1'b0, 1'b0);
        2: send_frame(8'($urandom), int'($urandom_range(0, 2)), NS, 1'b1, 1'b1);
        3: cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        4: repeat (int'($urandom_range(1, 4))) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
        default: send_frame(8'($urandom), int'($urandom_range(0, 3)), NS, 1'b1, 1'b0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
